arm_imm_encoder: RTL and testbench

//  Inverse of the operand-2 immediate decoder (addressing mode 1, A5.1.3): takes a 32-bit

---
 rtl/arm_imm_pkg.sv | 17 +
 rtl/arm_imm_encoder_if.sv | 24 ++
 rtl/imm_rot_check.sv | 20 ++
 rtl/arm_imm_encoder.sv | 176 +++++++++++++++++
 tb/tb_arm_imm_encoder.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/arm_imm_pkg.sv
// Shared types and constants for the ARM operand-2 immediate encoder.
package arm_imm_pkg;

  localparam int VALUE_W   = 32;
  localparam int ROT_STEPS = 16;
  localparam int IMM8_W    = 8;
  localparam int ROT_W     = 4;

  typedef logic [ROT_W+IMM8_W-1:0] imm12_t;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

endpackage

// File: rtl/arm_imm_encoder_if.sv
// Request/response bundle of the immediate encoder; master = requester, slave = encoder.
interface arm_imm_encoder_if;
  import arm_imm_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [VALUE_W-1:0] in_value;
  logic               out_valid;
  logic               out_ready;
  logic               out_found;
  imm12_t             out_imm12;
  logic               out_invert;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_found, out_imm12, out_invert
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_found, out_imm12, out_invert
  );

endinterface

// File: rtl/imm_rot_check.sv
// Tests one rotate_imm candidate k: hit when value ROL 2k fits in 8 bits.
module imm_rot_check
  import arm_imm_pkg::*;
(
  input  logic [VALUE_W-1:0] value,
  input  logic [ROT_W-1:0]   k,
  output logic               hit,
  output logic [IMM8_W-1:0]  immed_8
);

  logic [5:0]         shamt;
  logic [VALUE_W-1:0] rotl;

  // shamt=0 gives value >> 32, which is zero, so k=0 passes value through
  assign shamt   = {1'b0, k, 1'b0};
  assign rotl    = (value << shamt) | (value >> (6'd32 - shamt));
  assign hit     = (rotl[VALUE_W-1:IMM8_W] == '0);
  assign immed_8 = rotl[IMM8_W-1:0];

endmodule

// File: rtl/arm_imm_encoder.sv
// Iterative search for an {rotate_imm, immed_8} encoding of a 32-bit constant.
// Optional MVN form (search of ~value) enabled by defining ARM_IMM_MVN_EN.
module arm_imm_encoder
  import arm_imm_pkg::*;
#(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  arm_imm_encoder_if.slave bus
);

  state_t             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               found_q;
  imm12_t             imm12_q;
  logic [ROT_W-1:0]   rot;
  logic [VALUE_W-1:0] value_q;

  logic               last_chunk;
  logic [ROT_W-1:0]   cand_k   [CHECKS_PER_CYCLE];
  logic               cand_hit [CHECKS_PER_CYCLE];
  logic [IMM8_W-1:0]  cand_imm [CHECKS_PER_CYCLE];
  logic               pick_hit;
  imm12_t             pick_imm;

  assign last_chunk = (({1'b0, rot} + (ROT_W+1)'(CHECKS_PER_CYCLE)) == (ROT_W+1)'(ROT_STEPS));

  for (genvar i = 0; i < CHECKS_PER_CYCLE; i++) begin : g_plain
    assign cand_k[i] = rot + ROT_W'(i);
    imm_rot_check u_check (
      .value   (value_q),
      .k       (cand_k[i]),
      .hit     (cand_hit[i]),
      .immed_8 (cand_imm[i])
    );
  end

  // Descending scan so the lowest hitting k is the last one written
  always_comb begin
    pick_hit = 1'b0;
    pick_imm = '0;
    for (int i = CHECKS_PER_CYCLE - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        pick_hit = 1'b1;
        pick_imm = {cand_k[i], cand_imm[i]};
      end
    end
  end

`ifdef ARM_IMM_MVN_EN
  logic [VALUE_W-1:0] value_inv;
  logic               inv_hit [CHECKS_PER_CYCLE];
  logic [IMM8_W-1:0]  inv_b   [CHECKS_PER_CYCLE];
  logic               pick_inv_hit;
  imm12_t             pick_inv_imm;
  logic               inv_seen;
  imm12_t             inv_imm;
  logic               invert_q;

  assign value_inv = ~value_q;

  for (genvar i = 0; i < CHECKS_PER_CYCLE; i++) begin : g_inv
    imm_rot_check u_check (
      .value   (value_inv),
      .k       (cand_k[i]),
      .hit     (inv_hit[i]),
      .immed_8 (inv_b[i])
    );
  end

  always_comb begin
    pick_inv_hit = 1'b0;
    pick_inv_imm = '0;
    for (int i = CHECKS_PER_CYCLE - 1; i >= 0; i--) begin
      if (inv_hit[i]) begin
        pick_inv_hit = 1'b1;
        pick_inv_imm = {cand_k[i], inv_b[i]};
      end
    end
  end

  // The first inverted hit is parked until the plain form has been ruled out at every k
  always_ff @(posedge clk) begin
    if (state == SEARCH && !inv_seen && pick_inv_hit) begin
      inv_imm <= pick_inv_imm;
    end
  end

  assign bus.out_invert = invert_q;
`else
  assign bus.out_invert = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      value_q <= bus.in_value;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      found_q     <= 1'b0;
      imm12_q     <= '0;
      rot         <= '0;
`ifdef ARM_IMM_MVN_EN
      invert_q    <= 1'b0;
      inv_seen    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= SEARCH;
            in_ready_q <= 1'b0;
            rot        <= '0;
`ifdef ARM_IMM_MVN_EN
            inv_seen   <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          if (pick_hit) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            found_q     <= 1'b1;
            imm12_q     <= pick_imm;
`ifdef ARM_IMM_MVN_EN
            invert_q    <= 1'b0;
`endif
          end else if (last_chunk) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
`ifdef ARM_IMM_MVN_EN
            found_q     <= inv_seen | pick_inv_hit;
            invert_q    <= inv_seen | pick_inv_hit;
            imm12_q     <= inv_seen ? inv_imm : (pick_inv_hit ? pick_inv_imm : '0);
`else
            found_q     <= 1'b0;
            imm12_q     <= '0;
`endif
          end else begin
            rot <= rot + ROT_W'(CHECKS_PER_CYCLE);
`ifdef ARM_IMM_MVN_EN
            if (pick_inv_hit) begin
              inv_seen <= 1'b1;
            end
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_found = found_q;
  assign bus.out_imm12 = imm12_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed bench for arm_imm_encoder against a brute-force decoder-inverse model.
module tb_arm_imm_encoder;
  import arm_imm_pkg::*;

  localparam int CPC = 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  arm_imm_encoder_if bus();

  arm_imm_encoder #(.CHECKS_PER_CYCLE(CPC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic   exp_f   = 1'b0;
  logic   exp_inv = 1'b0;
  imm12_t exp_imm = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
  endfunction

  // Search every one of the 4096 decoder encodings, smallest rotation first
  function automatic void model(input logic [31:0] v, output logic f, output imm12_t imm,
                                output logic inv, output int cycles);
    f = 1'b0; imm = '0; inv = 1'b0; cycles = ROT_STEPS / CPC;
    for (int r = 0; r < ROT_STEPS && !f; r++)
      for (int b = 0; b < 256 && !f; b++)
        if (ror32(32'(b), 2 * r) == v) begin
          f = 1'b1; imm = {4'(r), 8'(b)}; cycles = r / CPC + 1;
        end
`ifdef ARM_IMM_MVN_EN
    for (int r = 0; r < ROT_STEPS && !f; r++)
      for (int b = 0; b < 256 && !f; b++)
        if (ror32(32'(b), 2 * r) == ~v) begin
          f = 1'b1; imm = {4'(r), 8'(b)}; inv = 1'b1;
        end
`endif
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1) begin
      check("out_found", 32'(bus.out_found), 32'(exp_f));
      check("out_imm12", 32'(bus.out_imm12), 32'(exp_imm));
      check("out_invert", 32'(bus.out_invert), 32'(exp_inv));
      check("in_ready_done", 32'(bus.in_ready), 32'd0);
    end
  end

  task automatic run(input string name, input logic [31:0] v, input logic lit_f,
                     input imm12_t lit_imm, input logic lit_inv, input int lit_lat, input int hold);
    int n; logic f; imm12_t im; logic iv; int cyc;
    model(v, f, im, iv, cyc);
    check({name, " model found"}, 32'(f), 32'(lit_f));
    check({name, " model imm12"}, 32'(im), 32'(lit_imm));
    check({name, " model invert"}, 32'(iv), 32'(lit_inv));
    check({name, " model latency"}, 32'(cyc), 32'(lit_lat));
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check({name, " in_ready wait"}, 32'(n < 50), 32'd1);
    exp_f = f; exp_imm = im; exp_inv = iv;
    bus.in_value = v; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    // a competing request during the search must be ignored
    bus.in_value = ~v;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
      bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check({name, " latency"}, 32'(n), 32'(cyc));
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    check({name, " out_valid held"}, 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    check({name, " in_ready back"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    check({name, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, " out_found"}, 32'(bus.out_found), 32'd0);
    check({name, " out_imm12"}, 32'(bus.out_imm12), 32'd0);
    check({name, " out_invert"}, 32'(bus.out_invert), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_value = '0; bus.out_ready = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    bus.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.out_ready = 1'b0;
    check("idle out_ready out_valid", 32'(bus.out_valid), 32'd0);
    check("idle out_ready in_ready", 32'(bus.in_ready), 32'd1);

    run("ff000000", 32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 4 / CPC + 1, 0);
    run("00000104", 32'h0000_0104, 1'b1, 12'hF41, 1'b0, 15 / CPC + 1, 0);
    run("00000101", 32'h0000_0101, 1'b0, 12'h000, 1'b0, 16 / CPC, 0);
    run("f000000f", 32'hF000_000F, 1'b1, 12'h2FF, 1'b0, 2 / CPC + 1, 10);
    run("zero", 32'h0000_0000, 1'b1, 12'h000, 1'b0, 1, 0);
    run("00000004", 32'h0000_0004, 1'b1, 12'h004, 1'b0, 1, 0);
`ifdef ARM_IMM_MVN_EN
    run("ffffff00", 32'hFFFF_FF00, 1'b1, 12'h0FF, 1'b1, 16 / CPC, 0);
`else
    run("ffffff00", 32'hFFFF_FF00, 1'b0, 12'h000, 1'b0, 16 / CPC, 0);
`endif

    bus.in_value = 32'h0000_0104; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check_reset_values("mid-search reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run("after reset", 32'hFF00_0000, 1'b1, 12'h4FF, 1'b0, 4 / CPC + 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
